// File: rtl/ram_io_resp.sv
// ram_io_resp: byte-wide memory-bus responder with RAM and a small I/O page
// (TX/RX FIFOs, status, halt). Every bus cycle is a transaction; reads return
// one cycle later on the registered rom_rn.
`timescale 1ns/1ps
module ram_io_resp #(
  parameter int unsigned RAM_AW   = 17,
  parameter int unsigned FIFO_AW  = 4,
  parameter string       RAM_INIT = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rom_a,
  input  logic [7:0]  rom_wn,
  input  logic        rom_wr,
  output logic [7:0]  rom_rn,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halted,
  output logic        tx_ovf
);

  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW         = FIFO_AW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [2:0]  OFF_DATA   = 3'd0;
  localparam logic [2:0]  OFF_STAT   = 3'd4;

  logic [7:0] ram [RAM_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [FIFO_AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0]      tx_cnt, rx_cnt;

  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        io_off;
  logic              is_io;
  logic              ram_we;
  logic              tx_full, rx_full, rx_nonempty;
  logic              tx_push_req, tx_push, tx_pop, tx_drop;
  logic              rx_push, rx_pop;
  logic              halt_set;
  logic [7:0]        io_rdata;
  logic              unused_addr;

  // Address bits above the decode window alias onto the same page.
  assign unused_addr = ^rom_a[31:18];

  // Bus decode and FIFO handshake qualification.
  assign ram_idx     = rom_a[RAM_AW-1:0];
  assign is_io       = rom_a[17];
  assign io_off      = rom_a[2:0];
  assign ram_we      = ~is_io & rom_wr & ~halted;

  assign tx_full     = (tx_cnt == FIFO_FULL);
  assign tx_valid    = (tx_cnt != '0);
  assign tx_data     = tx_mem[tx_rd];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = is_io & rom_wr & ~halted & (io_off == OFF_DATA);
  // A full FIFO still accepts a push when the host drains the head this cycle.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
  assign halt_set    = is_io & rom_wr & ~halted & (io_off == OFF_STAT);

  assign rx_full     = (rx_cnt == FIFO_FULL);
  assign rx_nonempty = (rx_cnt != '0);
  assign rx_pop      = is_io & ~rom_wr & (io_off == OFF_DATA) & rx_nonempty;
  // A full FIFO still accepts the host byte when the CPU pops this cycle.
  assign rx_ready    = ~rx_full | rx_pop;
  assign rx_push     = rx_valid & rx_ready;

  // I/O page read data.
  always_comb begin
    io_rdata = 8'h00;
    if (!rom_wr) begin
      case (io_off)
        OFF_DATA: io_rdata = rx_pop ? rx_mem[rx_rd] : 8'h00;
        OFF_STAT: io_rdata = {6'b0, tx_full, rx_nonempty};
        default:  io_rdata = 8'h00;
      endcase
    end
  end

  // RAM and FIFO storage writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we)  ram[ram_idx]  <= rom_wn;
    if (tx_push) tx_mem[tx_wr] <= rom_wn;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  // Read data, FIFO pointers/counts and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_rn <= 8'h00;
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      halted <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (is_io)       rom_rn <= io_rdata;
      else if (ram_we) rom_rn <= rom_wn;
      else             rom_rn <= ram[ram_idx];

      if (tx_push) tx_wr <= tx_wr + FIFO_AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + FIFO_AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);

      if (rx_push) rx_wr <= rx_wr + FIFO_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + FIFO_AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);

      if (halt_set) halted <= 1'b1;
      if (tx_drop)  tx_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_io_resp.sv
// Bench for ram_io_resp: queue-based behavioural model, scoreboard queues
// drained by independent monitors, directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_ram_io_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_a;
  logic [7:0]  rom_wn;
  logic        rom_wr;
  logic [7:0]  rom_rn;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halted;
  logic        tx_ovf;

  int checks = 0;
  int failures = 0;

  ram_io_resp dut (
    .clk(clk), .rst(rst), .rom_a(rom_a), .rom_wn(rom_wn), .rom_wr(rom_wr),
    .rom_rn(rom_rn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halted(halted), .tx_ovf(tx_ovf)
  );

  always #5 clk = ~clk;

  // Expected values after the edge, and before it (handshake side).
  typedef struct { bit [7:0] rn; bit chk_rn; bit hlt; bit ovf; } post_t;
  typedef struct { bit txv; bit rxr; bit pop; bit [7:0] txd; } pre_t;
  post_t post_q[$];
  pre_t  pre_q[$];

  // Behavioural model state.
  bit [7:0] mem_m [int];
  bit [7:0] tx_q[$];
  bit [7:0] rx_q[$];
  bit       m_halt;
  bit       m_ovf;

  function automatic void chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic idle_inputs();
    rom_a = 32'h10; rom_wn = 8'h00; rom_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
  endtask

  // One bus transaction: drive at negedge, advance the model, queue expectations.
  task automatic cyc(input logic [31:0] a, input logic [7:0] wn, input logic wr,
                     input logic txr, input logic [7:0] rxd, input logic rxv);
    pre_t p; post_t o; bit io; bit [2:0] off; bit rxpop; int idx;
    @(negedge clk);
    rom_a = a; rom_wn = wn; rom_wr = wr; tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    io = a[17]; off = a[2:0]; idx = int'(a[16:0]);
    p.txv = (tx_q.size() != 0);
    p.pop = p.txv && txr;
    p.txd = p.pop ? tx_q[0] : 8'h00;
    rxpop = io && !wr && off == 3'd0 && rx_q.size() != 0;
    p.rxr = (rx_q.size() < 16) || rxpop;
    o.chk_rn = 1'b1;
    if (io) begin
      if (wr)               o.rn = 8'h00;
      else if (off == 3'd0) o.rn = rxpop ? rx_q[0] : 8'h00;
      else if (off == 3'd4) o.rn = {6'b0, tx_q.size() == 16, rx_q.size() != 0};
      else                  o.rn = 8'h00;
    end else if (wr && !m_halt) begin
      o.rn = wn;
    end else if (wr) begin
      o.rn = 8'h00; o.chk_rn = 1'b0;
    end else begin
      o.rn = mem_m.exists(idx) ? mem_m[idx] : 8'h00;
    end
    if (p.pop) void'(tx_q.pop_front());
    if (rxpop) void'(rx_q.pop_front());
    if (wr && !m_halt) begin
      if (!io) mem_m[idx] = wn;
      else if (off == 3'd0) begin
        if (tx_q.size() < 16) tx_q.push_back(wn);
        else m_ovf = 1'b1;
      end else if (off == 3'd4) m_halt = 1'b1;
    end
    if (rxv && p.rxr) rx_q.push_back(rxd);
    o.hlt = m_halt; o.ovf = m_ovf;
    pre_q.push_back(p);
    post_q.push_back(o);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_halted",   {7'b0, halted},   8'h00);
    chk("rst_rom_rn",   rom_rn,           8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_tx_ovf",   {7'b0, tx_ovf},   8'h00);
    tx_q.delete(); rx_q.delete(); m_halt = 1'b0; m_ovf = 1'b0;
    pre_q.delete(); post_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Post-edge monitor: read data and sticky flags.
  initial begin
    post_t o;
    forever begin
      @(posedge clk);
      #1;
      if (post_q.size() > 0) begin
        o = post_q.pop_front();
        if (o.chk_rn) chk("rom_rn", rom_rn, o.rn);
        chk("halted", {7'b0, halted}, {7'b0, o.hlt});
        chk("tx_ovf", {7'b0, tx_ovf}, {7'b0, o.ovf});
      end
    end
  end

  // Pre-edge monitor: host-side handshakes and TX byte order.
  initial begin
    pre_t p;
    forever begin
      @(negedge clk);
      #2;
      if (pre_q.size() > 0) begin
        p = pre_q.pop_front();
        chk("tx_valid", {7'b0, tx_valid}, {7'b0, p.txv});
        chk("rx_ready", {7'b0, rx_ready}, {7'b0, p.rxr});
        if (p.pop) chk("tx_data", tx_data, p.txd);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] r;
    bit [2:0]  offs [6];
    offs[0] = 3'd1; offs[1] = 3'd2; offs[2] = 3'd3;
    offs[3] = 3'd5; offs[4] = 3'd6; offs[5] = 3'd7;
    m_halt = 1'b0; m_ovf = 1'b0;
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("init_rom_rn",   rom_rn,           8'h00);
    chk("init_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("init_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("init_halted",   {7'b0, halted},   8'h00);
    chk("init_tx_ovf",   {7'b0, tx_ovf},   8'h00);
    @(negedge clk);
    rst = 1'b0;

    // RAM write-then-read and empty RX read.
    cyc(32'h10, 8'hA5, 1, 0, 0, 0);
    cyc(32'h10, 8'h00, 0, 0, 0, 0);
    cyc(32'h0002_0010, 8'h00, 0, 0, 0, 0);

    // TX fill to 16, overflow, status, then drain in order.
    for (int i = 1; i <= 16; i++) cyc(32'h30000, 8'(i), 1, 0, 0, 0);
    cyc(32'h30000, 8'h11, 1, 0, 0, 0);
    cyc(32'h30004, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) cyc(32'h10, 8'h00, 0, 1, 0, 0);

    // Full TX with simultaneous push and pop.
    do_reset();
    for (int i = 1; i <= 16; i++) cyc(32'h30000, 8'(i + 32), 1, 0, 0, 0);
    cyc(32'h30000, 8'h77, 1, 1, 0, 0);
    cyc(32'h30004, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(32'h10, 8'h00, 0, 1, 0, 0);

    // RX path.
    cyc(32'h10, 8'h00, 0, 0, 8'h41, 1);
    cyc(32'h10, 8'h00, 0, 0, 8'h42, 1);
    cyc(32'h30004, 8'h00, 0, 0, 0, 0);
    cyc(32'h30000, 8'h00, 0, 0, 0, 0);
    cyc(32'h30000, 8'h00, 0, 0, 0, 0);
    cyc(32'h30000, 8'h00, 0, 0, 0, 0);
    cyc(32'h30004, 8'h00, 0, 0, 0, 0);

    // Random traffic over a pre-written RAM window and the I/O page.
    for (int k = 0; k < 16; k++) cyc(32'h100 + 32'(k), 8'($urandom()), 1, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [7:0]  wn;
      logic        wr;
      int          sel;
      r   = $urandom();
      sel = $urandom_range(0, 9);
      wn  = 8'($urandom());
      wr  = 1'b0;
      case (sel)
        0, 1, 2, 9: a = {r[31:18], 1'b0, 17'(32'h100 + 32'($urandom_range(0, 15)))};
        3: begin a = {r[31:18], 1'b0, 17'(32'h100 + 32'($urandom_range(0, 15)))}; wr = 1'b1; end
        4, 5: a = {r[31:18], 1'b1, 14'(r[13:0]), 3'd0};
        6: a = {r[31:18], 1'b1, 14'(r[13:0]), 3'd4};
        7: begin a = {r[31:18], 1'b1, 14'(r[13:0]), 3'd0}; wr = 1'b1; end
        default: begin
          a = {r[31:18], 1'b1, 14'(r[13:0]), offs[$urandom_range(0, 5)]};
          wr = 1'(r[0]);
        end
      endcase
      cyc(a, wn, wr, 1'($urandom_range(0, 1)), 8'($urandom()), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) cyc(32'h30000, 8'h00, 0, 1, 0, 0);

    // Halt: writes ignored, reads still work.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(32'h30000, 8'(8'hC0 + 8'(i)), 1, 0, 0, 0);
    cyc(32'h30004, 8'h00, 1, 0, 0, 0);
    cyc(32'h10, 8'hFF, 1, 0, 0, 0);
    cyc(32'h10, 8'h00, 0, 0, 0, 0);
    cyc(32'h30000, 8'h99, 1, 0, 0, 0);
    cyc(32'h30004, 8'h00, 0, 0, 0, 0);

    // Asynchronous reset with TX queued and halted; RAM survives.
    do_reset();
    cyc(32'h10, 8'h00, 0, 0, 0, 0);
    cyc(32'h30004, 8'h00, 0, 0, 0, 0);
    cyc(32'h10, 8'h00, 0, 0, 0, 0);

    @(posedge clk);
    #3;
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
